// File: rtl/req_ack_responder.sv
// Req/ack responder: each accepted req is buffered and acked one cycle later.
// A full FIFO rejects the req (drop pulse, counted) unless a pop happens on the same edge.
module req_ack_responder #(
   parameter int DW    = 8,
   parameter int DEPTH = 4,
   parameter int CW    = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     req,
   input  logic [DW-1:0]            req_data,
   output logic                     ack,
   output logic                     drop,
   output logic                     out_valid,
   output logic [DW-1:0]            out_data,
   input  logic                     out_ready,
   output logic [$clog2(DEPTH):0]   count,
   output logic [CW-1:0]            drop_cnt
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
   localparam logic [AW:0] CNT_ONE  = (AW+1)'(1);
   localparam logic [AW-1:0] PTR_ONE = AW'(1);
   localparam logic [CW-1:0] DC_ONE  = CW'(1);

   logic [DW-1:0] mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          pop;
   logic          push_ok;
   logic          reject;

   assign out_valid = (count != '0);
   assign out_data  = out_valid ? mem[rd_ptr] : '0;
   assign pop       = out_valid & out_ready;
   // Gated by rst so the unreset memory is never written while in reset.
   assign push_ok   = ~rst & req & ((count < FULL_CNT) | pop);
   assign reject    = ~rst & req & ~push_ok;

   always_ff @(posedge clk) begin
      if (push_ok)
         mem[wr_ptr] <= req_data;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ack      <= 1'b0;
         drop     <= 1'b0;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         drop_cnt <= '0;
      end else begin
         ack  <= push_ok;
         drop <= reject;
         if (reject && (drop_cnt != '1))
            drop_cnt <= drop_cnt + DC_ONE;
         // DEPTH is a power of two, so pointer overflow is the modulo wrap.
         if (push_ok)
            wr_ptr <= wr_ptr + PTR_ONE;
         if (pop)
            rd_ptr <= rd_ptr + PTR_ONE;
         if (push_ok && !pop)
            count <= count + CNT_ONE;
         else if (!push_ok && pop)
            count <= count - CNT_ONE;
      end
   end

endmodule

// File: tb/tb_req_ack_responder.sv
// Scoreboard bench for req_ack_responder (DEPTH=4) plus a CW=2 instance for drop-counter saturation.
module tb_req_ack_responder;

   logic       clk = 1'b0;
   logic       rst;
   logic       req;
   logic [7:0] req_data;
   logic       ack;
   logic       drop;
   logic       out_valid;
   logic [7:0] out_data;
   logic       out_ready;
   logic [2:0] count;
   logic [7:0] drop_cnt;

   logic       req2;
   logic [7:0] req_data2;
   logic       ack2;
   logic       drop2;
   logic       out_valid2;
   logic [7:0] out_data2;
   logic       out_ready2;
   logic [2:0] count2;
   logic [1:0] drop_cnt2;

   int vectors = 0;
   int miscompares = 0;

   logic [7:0] exp_q[$];
   int         mcnt = 0;
   int         mdc  = 0;
   logic       exp_ack;
   logic       exp_drop;

   always #5 clk = ~clk;

   req_ack_responder #(.DW(8), .DEPTH(4), .CW(8)) dut (
      .clk(clk), .rst(rst), .req(req), .req_data(req_data),
      .ack(ack), .drop(drop), .out_valid(out_valid), .out_data(out_data),
      .out_ready(out_ready), .count(count), .drop_cnt(drop_cnt)
   );

   req_ack_responder #(.DW(8), .DEPTH(4), .CW(2)) dut2 (
      .clk(clk), .rst(rst), .req(req2), .req_data(req_data2),
      .ack(ack2), .drop(drop2), .out_valid(out_valid2), .out_data(out_data2),
      .out_ready(out_ready2), .count(count2), .drop_cnt(drop_cnt2)
   );

   assert property (@(posedge clk) disable iff (rst)
      (req && ((count < 3'd4) || (out_valid && out_ready))) |=> ack)
      else begin
         miscompares++;
         $display("FAIL prop_req_ack: accepted req not followed by ack");
      end

   assert property (@(posedge clk) disable iff (rst) ack |-> !drop)
      else begin
         miscompares++;
         $display("FAIL prop_ack_drop_excl: ack and drop both high");
      end

   assert property (@(posedge clk) count <= 3'd4)
      else begin
         miscompares++;
         $display("FAIL prop_count_bound: count=%0d exceeds 4", count);
      end

   // Drive one cycle from a negedge, update the reference model, return at the next negedge.
   task automatic drive(input logic r, input logic [7:0] d, input logic rdy);
      logic pop_m;
      logic push_m;
      req       = r;
      req_data  = d;
      out_ready = rdy;
      pop_m  = (mcnt != 0) && rdy;
      push_m = r && ((mcnt < 4) || pop_m);
      if (pop_m)  void'(exp_q.pop_front());
      if (push_m) exp_q.push_back(d);
      mcnt     = mcnt + int'(push_m) - int'(pop_m);
      exp_ack  = push_m;
      exp_drop = r && !push_m;
      if (exp_drop && mdc != 255) mdc++;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic test_reset();
      #30 req = 1'b1; req_data = 8'h5A;
      #6;
      vectors++;
      if (ack !== 1'b0 || drop !== 1'b0) begin
         miscompares++;
         $display("FAIL rst_req_ignored: ack=%b drop=%b, required 0 0", ack, drop);
      end
      vectors++;
      if (count !== 3'd0) begin
         miscompares++;
         $display("FAIL rst_no_write: count=%0d, required 0", count);
      end
      #4 req = 1'b0;
      #10 rst = 1'b0;
      vectors++;
      if ({ack, drop, out_valid, out_data, count, drop_cnt} !== '0) begin
         miscompares++;
         $display("FAIL rst_outputs: ack=%b drop=%b vld=%b dat=%h cnt=%0d dcnt=%0d, required all 0",
                  ack, drop, out_valid, out_data, count, drop_cnt);
      end
   endtask

   task automatic test_single();
      drive(1'b1, 8'hA5, 1'b1);
      vectors++;
      if (ack !== 1'b1 || out_valid !== 1'b1) begin
         miscompares++;
         $display("FAIL single_ack_vld: ack=%b vld=%b, required 1 1", ack, out_valid);
      end
      vectors++;
      if (out_data !== 8'hA5) begin
         miscompares++;
         $display("FAIL single_data: got %h, required a5", out_data);
      end
      drive(1'b0, 8'h00, 1'b1);
      vectors++;
      if (count !== 3'd0 || out_valid !== 1'b0 || out_data !== 8'h00 || ack !== 1'b0) begin
         miscompares++;
         $display("FAIL single_drain: cnt=%0d vld=%b dat=%h ack=%b, required 0 0 00 0",
                  count, out_valid, out_data, ack);
      end
   endtask

   task automatic test_overflow();
      for (int i = 1; i <= 6; i++) begin
         drive(1'b1, 8'(i), 1'b0);
         vectors++;
         if (ack !== exp_ack || drop !== exp_drop) begin
            miscompares++;
            $display("FAIL ovf_ack_drop[%0d]: ack=%b drop=%b, required %b %b",
                     i, ack, drop, exp_ack, exp_drop);
         end
      end
      vectors++;
      if (drop_cnt !== 8'd2 || count !== 3'd4) begin
         miscompares++;
         $display("FAIL ovf_counts: dcnt=%0d cnt=%0d, required 2 4", drop_cnt, count);
      end
      vectors++;
      if (out_data !== 8'd1) begin
         miscompares++;
         $display("FAIL ovf_head_stable: got %h, required 01", out_data);
      end
      for (int i = 0; i < 4; i++) begin
         vectors++;
         if (out_valid !== 1'b1 || out_data !== exp_q[0]) begin
            miscompares++;
            $display("FAIL ovf_drain[%0d]: vld=%b dat=%h, required 1 %h", i, out_valid, out_data, exp_q[0]);
         end
         drive(1'b0, 8'h00, 1'b1);
      end
      vectors++;
      if (count !== 3'd0 || drop !== 1'b0) begin
         miscompares++;
         $display("FAIL ovf_empty: cnt=%0d drop=%b, required 0 0", count, drop);
      end
   endtask

   task automatic test_full_pop();
      for (int i = 0; i < 4; i++) drive(1'b1, 8'h10 + 8'(i), 1'b0);
      vectors++;
      if (count !== 3'd4) begin
         miscompares++;
         $display("FAIL fp_fill: cnt=%0d, required 4", count);
      end
      vectors++;
      if (out_data !== exp_q[0]) begin
         miscompares++;
         $display("FAIL fp_head: got %h, required %h", out_data, exp_q[0]);
      end
      drive(1'b1, 8'h77, 1'b1);
      vectors++;
      if (ack !== 1'b1 || drop !== 1'b0 || count !== 3'd4) begin
         miscompares++;
         $display("FAIL fp_push_pop: ack=%b drop=%b cnt=%0d, required 1 0 4", ack, drop, count);
      end
      for (int i = 0; i < 4; i++) begin
         vectors++;
         if (out_data !== exp_q[0]) begin
            miscompares++;
            $display("FAIL fp_drain[%0d]: got %h, required %h", i, out_data, exp_q[0]);
         end
         if (i == 3) begin
            vectors++;
            if (out_data !== 8'h77) begin
               miscompares++;
               $display("FAIL fp_last_word: got %h, required 77", out_data);
            end
         end
         drive(1'b0, 8'h00, 1'b1);
      end
   endtask

   task automatic test_mid_reset();
      drive(1'b1, 8'h11, 1'b0);
      drive(1'b1, 8'h22, 1'b0);
      vectors++;
      if (ack !== 1'b1 || count !== 3'd2) begin
         miscompares++;
         $display("FAIL mr_fill: ack=%b cnt=%0d, required 1 2", ack, count);
      end
      #1 req = 1'b0;
      #1 rst = 1'b1;
      #1;
      vectors++;
      if (ack !== 1'b0 || out_valid !== 1'b0 || count !== 3'd0 || out_data !== 8'h00) begin
         miscompares++;
         $display("FAIL mr_async: ack=%b vld=%b cnt=%0d dat=%h, required 0 0 0 00",
                  ack, out_valid, count, out_data);
      end
      exp_q.delete();
      mcnt = 0;
      mdc  = 0;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      drive(1'b1, 8'h3C, 1'b0);
      vectors++;
      if (ack !== 1'b1 || out_data !== exp_q[0] || count !== 3'd1) begin
         miscompares++;
         $display("FAIL mr_after: ack=%b dat=%h cnt=%0d, required 1 %h 1", ack, out_data, count, exp_q[0]);
      end
      drive(1'b0, 8'h00, 1'b1);
      vectors++;
      if (count !== 3'd0 || drop_cnt !== 8'(mdc)) begin
         miscompares++;
         $display("FAIL mr_drain: cnt=%0d dcnt=%0d, required 0 %0d", count, drop_cnt, mdc);
      end
   endtask

   task automatic test_drop_saturate();
      int drops = 0;
      int acks  = 0;
      out_ready2 = 1'b0;
      for (int i = 0; i < 9; i++) begin
         req2 = 1'b1;
         req_data2 = 8'(i);
         @(posedge clk);
         @(negedge clk);
         if (drop2) drops++;
         if (ack2)  acks++;
      end
      req2 = 1'b0;
      vectors++;
      if (drop_cnt2 !== 2'd3) begin
         miscompares++;
         $display("FAIL sat_drop_cnt: got %0d, required 3", drop_cnt2);
      end
      vectors++;
      if (drops != 5 || acks != 4) begin
         miscompares++;
         $display("FAIL sat_pulses: drops=%0d acks=%0d, required 5 4", drops, acks);
      end
      vectors++;
      if (count2 !== 3'd4 || out_valid2 !== 1'b1 || out_data2 !== 8'h00) begin
         miscompares++;
         $display("FAIL sat_fifo: cnt=%0d vld=%b dat=%h, required 4 1 00", count2, out_valid2, out_data2);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      rst        = 1'b1;
      req        = 1'b0;
      req_data   = 8'h00;
      out_ready  = 1'b0;
      req2       = 1'b0;
      req_data2  = 8'h00;
      out_ready2 = 1'b0;
      test_reset();
      test_single();
      test_overflow();
      test_full_pop();
      test_mid_reset();
      test_drop_saturate();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/req_ack_responder.md
Name: req_ack_responder

Overview:
- Downstream responder for the single-cycle req/ack handshake used across the bench and RTL.
- For every cycle it samples req high with free space, it captures req_data into an internal FIFO and asserts ack on the following cycle. This satisfies the protocol rule "req |=> ack" outside reset.
- It drains buffered words to the next stage over a valid/ready interface.
- It reports requests it could not accept because the FIFO was full.

Parameters:
DW, 8, width of req_data / out_data
DEPTH, 4, FIFO entries; power of two, ≥2
CW, 8, width of saturating drop counter

Ports:
clk  input  1  system clock, all state on posedge
rst  input  1  asynchronous, active-high reset
req  input  1  request, sampled each posedge; each high cycle is one transaction
req_data  input  DW  payload qualified by req
ack  output  1  registered; high the cycle after an accepted req
drop  output  1  registered; high the cycle after a rejected req
out_valid  output  1  FIFO non-empty
out_data  output  DW  FIFO head word; forced 0 when out_valid=0
out_ready  input  1  downstream accepts head when out_valid & out_ready at posedge
count  output  $clog2(DEPTH)+1  current FIFO occupancy
drop_cnt  output  CW  saturating count of rejected reqs

Behaviour:
- Reset (rst=1, asynchronous assert, released synchronously by the clock domain):
  - ack=0, drop=0, out_valid=0, out_data=0, count=0, drop_cnt=0.
  - Read/write pointers return to 0. Memory contents are not reset.
- While rst=1, req is ignored completely. No ack, no drop, no FIFO write.
- pop = out_valid & out_ready at the posedge.
- push_ok = req & (count<DEPTH | pop), evaluated with pre-edge count.
  - A full FIFO with a simultaneous pop accepts the new req.
- On push_ok:
  - write req_data at wr_ptr.
  - wr_ptr increments modulo DEPTH, wrapping DEPTH-1 -> 0.
  - ack=1 next cycle, otherwise ack=0.
- On req & ~push_ok:
  - no write.
  - drop=1 next cycle.
  - drop_cnt increments, saturating at 2^CW-1.
  - ack stays 0.
- On pop: rd_ptr increments modulo DEPTH.
- count_next = count + push_ok - pop.
  - Simultaneous push and pop leaves count unchanged.
  - Never exceeds DEPTH; never underflows, since pop requires out_valid.
- Latency: a word pushed into an empty FIFO at edge N gives out_valid=1 and out_data=that word after edge N. This is the same cycle ack is high.
  - There is no bypass; out_valid never rises in the cycle req is first high.
- Back-to-back req (held k cycles) = k transactions.
  - ack is high for k consecutive cycles, shifted by one, as long as space exists.
  - The first rejected cycle produces drop instead of ack.
- ack and drop are mutually exclusive every cycle.
- Ordering is strict FIFO. out_data is stable while out_valid=1 and out_ready=0.
- Reset asserted mid-operation:
  - all outputs go to reset values immediately (asynchronously).
  - buffered words are discarded.
  - a pending ack is not issued.
- First edge after rst deasserts: req is sampled normally.
- Bench-side checker obligations:
  - concurrent properties "req & (count<DEPTH | pop) |=> ack" and "ack |-> !drop", both disable iff (rst).
  - count<=DEPTH always.

Test Plan:
- rst=1 for 50 time units; req pulses at t=30 -> no ack and no drop during reset; all outputs 0 at release.
- After reset, out_ready=1; req=1 with req_data=8'hA5 for one cycle -> ack=1 next cycle, out_valid=1 with out_data=8'hA5 same cycle, popped; count back to 0.
- out_ready=0; req held 6 cycles with data 1..6, DEPTH=4 -> ack for the data 1-4 cycles; drop for 5 and 6; drop_cnt=2; count=4.
  - Then out_ready=1 -> outputs 1,2,3,4 in order.
- FIFO full (count=4), out_ready=1 and req=1 with 8'h77 in the same cycle -> ack=1, count stays 4; 8'h77 emerges after the 4 older words (pointer wrap exercised).
- Fill 2 entries, assert rst asynchronously between edges -> ack, out_valid, count drop to 0 immediately; after release a new req 8'h3C emerges first.
- CW=2: force 5 rejected reqs -> drop_cnt sticks at 3; drop pulses 5 times.
